seg_scan_ctrl: RTL and testbench
================================

# seg_scan_ctrl

Scan controller for the 4-digit seven-segment display. It time-multiplexes a 16-bit hex value across the four digits with a fixed dwell per digit and a blanking gap between digits to suppress ghosting. New values are buffered and applied only at frame boundaries, so the display never tears. It sits between the counter/datapath logic and the board's `an`/`seg`/`dp` pins, replacing per-digit switch selection.

## Interface
- `DWELL_CYC`, default 100000: clocks each digit is driven (1 ms at 100 MHz); must be ≥ 1.
- `BLANK_CYC`, default 1000: clocks all anodes are off between digits; must be ≥ 1.
- `clk` in 1: 100 MHz clock.
- `rst` in 1: reset, asynchronous, active-high.
- `en` in 1: scan enable; 0 means display dark.
- `load` in 1: one-cycle strobe that captures `din` and `dp_in`.
- `din` in 16: hex value; [15:12] is the leftmost digit (digit 0), [3:0] the rightmost (digit 3).
- `dp_in` in 4: decimal points; bit 3 is digit 0 (leftmost).
- `lz_blank` in 1: leading-zero suppression enable.
- `an` out 4: anodes, one-hot active-high; an[3] is the leftmost digit.
- `seg` out 7: segments g..a, active-low.
- `dp` out 1: decimal point, active-low.
- `frame_done` out 1: one-cycle pulse at the end of each full 4-digit frame.
- `pending` out 1: high while a loaded value is waiting for the frame boundary.

## Operation
- Registers:
  - `stage_val`/`stage_dp`: staging copy of the last load.
  - `disp_val`/`disp_dp`: the value currently being shown.
  - `pending` flag, 2-bit digit index `idx`, and dwell/blank counter sized by `$clog2` of the larger parameter.
- FSM states are IDLE, DRIVE, BLANK.
  - IDLE: `an`=0000, `seg`=7F, `dp`=1. If `en`=1, go to DRIVE with `idx`=0 and the counter cleared.
  - DRIVE: drive the digit at `idx` for DWELL_CYC clocks, then go to BLANK.
  - BLANK: `an`=0000 for BLANK_CYC clocks. At the end, `idx` increments modulo 4 and the FSM returns to DRIVE.
  - Frame end: when BLANK ends with `idx`=3, pulse `frame_done`. If `pending`=1, copy stage to disp and clear `pending` in the same cycle.
  - `en` falling in any state forces IDLE on the next clock; the counter and `idx` reset to 0.
- Load rules:
  - `load`=1 captures `din`/`dp_in` into stage and sets `pending`.
  - A load while `pending`=1 overwrites the stage; last load wins.
  - If the FSM is in IDLE (`en`=0), the load goes directly to disp and `pending` stays 0.
  - If `load` coincides with the frame-end transfer, the new stage value is captured and `pending` stays 1. The old stage value is the one transferred.
- Decode:
  - The nibble goes through hex-to-7seg with the standard 0–F glyphs.
  - Leading-zero suppression: with `lz_blank`=1, digit k<3 is blanked (`seg`=7F) if nibbles 0..k are all zero. Digit 3 is always shown.
  - `dp` follows `disp_dp` even on a blanked digit.

## Timing
- Reset values: `an`=0000, `seg`=7F, `dp`=1, `frame_done`=0, `pending`=0, stage=disp=0, state IDLE.
- Reset mid-frame blanks the outputs immediately (asynchronous) and discards any pending value.
- `an`/`seg`/`dp` are registered and change one clock after the FSM state or `idx` changes.
- The first DRIVE is visible 2 clocks after `en` rises.
- Digit period is DWELL_CYC+BLANK_CYC clocks; frame period is 4×(DWELL_CYC+BLANK_CYC).
- Worst-case load-to-display latency is one frame plus one digit period.
- `frame_done` is high for exactly one clock, aligned with the first clock of the new frame's DRIVE state (before the output register).

## Structure
- Shared package holds:
  - FSM state encoding (IDLE/DRIVE/BLANK).
  - Constants SEG_OFF=7'h7F and AN_OFF=4'b0000.
  - Digit count 4.
- One sub-module: `seg_hex_dec`, a purely combinational decoder (4-bit nibble in, 7-bit active-high segments out). The top level inverts its output.

## Test plan
All scenarios use DWELL_CYC=4 and BLANK_CYC=2.
- Reset, then `en`=1 with no load: each digit shows "0" (`seg`=7'h40); `an` sequence is 1000→0000→0100→0000→0010→0000→0001; frame of 24 clocks; `frame_done` every 24 clocks.
- Load 16'h12AF mid-frame at digit 1: digits 1–3 still show 0; `pending`=1; the next frame shows 1,2,A,F; `pending` clears at the `frame_done` cycle.
- `lz_blank`=1 with load 16'h0005: digits 0–2 show `seg`=7F; digit 3 shows "5" (`seg`=7'h12). Load 16'h0000: digits 0–2 blank, digit 3 shows "0".
- Two loads (16'h1111 then 16'h2222) within one frame: the next frame shows 2222 only. A load on the exact frame-end cycle: the old stage is transferred and `pending` stays 1.
- `en`=0 with load 16'hBEEF: outputs stay dark. Raising `en`: BEEF appears with digit 0 two clocks later. Dropping `en` mid-DRIVE: `an`=0000 one clock later.
- `rst` asserted mid-BLANK with `pending`=1: outputs go off immediately. After release with `en`=1, the display shows 0000 and `pending`=0.

Source files
------------

// File: rtl/seg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package seg_scan_ctrl_pkg;

  typedef enum logic [1:0] {StIdle, StDrive, StBlank} state_e;

  localparam logic [6:0]  SEG_OFF    = 7'h7F;
  localparam logic [3:0]  AN_OFF     = 4'b0000;
  localparam int unsigned NUM_DIGITS = 4;

  // Digit 0 is the leftmost, i.e. the most significant nibble.
  function automatic logic [3:0] digit_nibble(logic [15:0] val, logic [1:0] idx);
    logic [1:0] pos;
    pos = 2'd3 - idx;
    return val[{pos, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Display-side bundle: value/strobe inputs plus anode, segment and status outputs.
interface seg_scan_ctrl_if
  import seg_scan_ctrl_pkg::*;
;
  logic                  en;
  logic                  load;
  logic [15:0]           din;
  logic [NUM_DIGITS-1:0] dp_in;
  logic                  lz_blank;
  logic [NUM_DIGITS-1:0] an;
  logic [6:0]            seg;
  logic                  dp;
  logic                  frame_done;
  logic                  pending;

  modport master (
    output en, load, din, dp_in, lz_blank,
    input  an, seg, dp, frame_done, pending
  );

  modport slave (
    input  en, load, din, dp_in, lz_blank,
    output an, seg, dp, frame_done, pending
  );

endinterface

// File: rtl/seg_hex_dec.sv
// Combinational hex to seven-segment decoder, active-high, bit order g..a.
module seg_hex_dec (
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  always_comb begin
    seg = 7'h00;
    case (nibble)
      4'h0: seg = 7'h3F;
      4'h1: seg = 7'h06;
      4'h2: seg = 7'h5B;
      4'h3: seg = 7'h4F;
      4'h4: seg = 7'h66;
      4'h5: seg = 7'h6D;
      4'h6: seg = 7'h7D;
      4'h7: seg = 7'h07;
      4'h8: seg = 7'h7F;
      4'h9: seg = 7'h6F;
      4'hA: seg = 7'h77;
      4'hB: seg = 7'h7C;
      4'hC: seg = 7'h39;
      4'hD: seg = 7'h5E;
      4'hE: seg = 7'h79;
      4'hF: seg = 7'h71;
      default: seg = 7'h00;
    endcase
  end

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit seven-segment scanner with inter-digit blanking and frame-aligned value update.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int unsigned DWELL_CYC = 100000,
  parameter int unsigned BLANK_CYC = 1000
) (
  input logic            clk,
  input logic            rst,
  seg_scan_ctrl_if.slave bus
);

  localparam int unsigned MAX_CYC = (DWELL_CYC > BLANK_CYC) ? DWELL_CYC : BLANK_CYC;
  localparam int unsigned CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYC - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);

  state_e                state;
  logic [CNT_W-1:0]      cnt;
  logic [1:0]            idx;
  logic [15:0]           stage_val, disp_val;
  logic [NUM_DIGITS-1:0] stage_dp, disp_dp;
  logic                  pending_q, frame_done_q, dp_q;
  logic [NUM_DIGITS-1:0] an_q;
  logic [6:0]            seg_q;

  logic [3:0]            nib;
  logic [6:0]            seg_on;
  logic [NUM_DIGITS-1:0] zero_run;
  logic                  lz_hide, dwell_end, blank_end, frame_end;

  seg_hex_dec u_dec (
    .nibble(nib),
    .seg   (seg_on)
  );

  always_comb begin
    nib      = digit_nibble(disp_val, idx);
    zero_run = '0;
    // zero_run[k]: nibbles 0..k are all zero
    zero_run[0] = (digit_nibble(disp_val, 2'd0) == 4'h0);
    for (int k = 1; k < NUM_DIGITS; k++) begin
      zero_run[k] = zero_run[k-1] && (digit_nibble(disp_val, 2'(k)) == 4'h0);
    end
    lz_hide   = bus.lz_blank && (idx != 2'd3) && zero_run[idx];
    dwell_end = (cnt == DWELL_LAST);
    blank_end = (cnt == BLANK_LAST);
    frame_end = bus.en && (state == StBlank) && blank_end && (idx == 2'd3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= StIdle;
      cnt          <= '0;
      idx          <= '0;
      stage_val    <= '0;
      stage_dp     <= '0;
      disp_val     <= '0;
      disp_dp      <= '0;
      pending_q    <= 1'b0;
      frame_done_q <= 1'b0;
      an_q         <= AN_OFF;
      seg_q        <= SEG_OFF;
      dp_q         <= 1'b1;
    end else begin
      frame_done_q <= frame_end;

      if (!bus.en) begin
        state <= StIdle;
        cnt   <= '0;
        idx   <= '0;
      end else begin
        unique case (state)
          StIdle: begin
            state <= StDrive;
            cnt   <= '0;
            idx   <= '0;
          end
          StDrive: begin
            if (dwell_end) begin
              state <= StBlank;
              cnt   <= '0;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          StBlank: begin
            if (blank_end) begin
              state <= StDrive;
              cnt   <= '0;
              idx   <= idx + 1'b1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
          default: state <= StIdle;
        endcase
      end

      // Gating with en makes a dropped enable darken the pins on the very next edge.
      if (bus.en && (state == StDrive)) begin
        an_q  <= 4'b1000 >> idx;
        seg_q <= lz_hide ? SEG_OFF : ~seg_on;
        dp_q  <= ~disp_dp[2'd3 - idx];
      end else begin
        an_q  <= AN_OFF;
        seg_q <= SEG_OFF;
        dp_q  <= 1'b1;
      end

      if (bus.load) begin
        stage_val <= bus.din;
        stage_dp  <= bus.dp_in;
      end

      if (state == StIdle) begin
        if (bus.load) begin
          disp_val  <= bus.din;
          disp_dp   <= bus.dp_in;
          pending_q <= 1'b0;
        end
      end else if (frame_end && pending_q) begin
        // Old stage moves to display; a coincident load stays queued.
        disp_val  <= stage_val;
        disp_dp   <= stage_dp;
        pending_q <= bus.load;
      end else if (bus.load) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.an         = an_q;
  assign bus.seg        = seg_q;
  assign bus.dp         = dp_q;
  assign bus.frame_done = frame_done_q;
  assign bus.pending    = pending_q;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with DWELL_CYC=4, BLANK_CYC=2 (24-clock frame).
module tb_seg_scan_ctrl;

  localparam logic [6:0] S0  = 7'h40;
  localparam logic [6:0] S1  = 7'h79;
  localparam logic [6:0] S2  = 7'h24;
  localparam logic [6:0] S3  = 7'h30;
  localparam logic [6:0] S4  = 7'h19;
  localparam logic [6:0] S5  = 7'h12;
  localparam logic [6:0] SA  = 7'h08;
  localparam logic [6:0] SB  = 7'h03;
  localparam logic [6:0] SE  = 7'h06;
  localparam logic [6:0] SF  = 7'h0E;
  localparam logic [6:0] OFF = 7'h7F;

  logic clk;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  seg_scan_ctrl_if bus ();

  seg_scan_ctrl #(
    .DWELL_CYC(4),
    .BLANK_CYC(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(string tag, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic load_val(logic [15:0] v, logic [3:0] d);
    bus.din   = v;
    bus.dp_in = d;
    bus.load  = 1'b1;
    step(1);
    bus.load  = 1'b0;
  endtask

  task automatic wait_fd(string tag);
    int n = 0;
    do begin
      step(1);
      n++;
    end while (!bus.frame_done && n < 60);
    check_eq({tag, "_fd_seen"}, 32'(bus.frame_done), 32'd1);
  endtask

  // Entered on the frame_done cycle; leaves while digit 3 is on the pins.
  task automatic check_frame(string tag, logic [6:0] s0, logic [6:0] s1, logic [6:0] s2,
                             logic [6:0] s3, logic [3:0] dpx);
    logic [6:0] s [4];
    s = '{s0, s1, s2, s3};
    for (int k = 0; k < 4; k++) begin
      step((k == 0) ? 1 : 2);
      check_eq($sformatf("%s_an%0d", tag, k), 32'(bus.an), 32'h8 >> k);
      check_eq($sformatf("%s_seg%0d", tag, k), 32'(bus.seg), 32'(s[k]));
      check_eq($sformatf("%s_dp%0d", tag, k), 32'(bus.dp), 32'(dpx[3-k]));
      if (k < 3) begin
        step(4);
        check_eq($sformatf("%s_gap%0d", tag, k), 32'(bus.an), 32'h0);
      end
    end
  endtask

  initial begin
    rst          = 1'b1;
    bus.en       = 1'b0;
    bus.load     = 1'b0;
    bus.din      = '0;
    bus.dp_in    = '0;
    bus.lz_blank = 1'b0;
    step(2);
    check_eq("rst_an", 32'(bus.an), 32'h0);
    check_eq("rst_seg", 32'(bus.seg), 32'h7F);
    check_eq("rst_dp", 32'(bus.dp), 32'h1);
    check_eq("rst_fd", 32'(bus.frame_done), 32'h0);
    check_eq("rst_pend", 32'(bus.pending), 32'h0);
    rst = 1'b0;
    step(1);

    // Enable with nothing loaded: zeros on every digit
    bus.en = 1'b1;
    step(1);
    check_eq("pre_drive_an", 32'(bus.an), 32'h0);
    step(1);
    check_eq("first_drive_an", 32'(bus.an), 32'h8);
    check_eq("first_drive_seg", 32'(bus.seg), 32'(S0));
    wait_fd("f0");
    check_eq("f0_pend", 32'(bus.pending), 32'h0);
    check_frame("zero", S0, S0, S0, S0, 4'b1111);
    step(4);
    check_eq("fd_low", 32'(bus.frame_done), 32'h0);
    step(1);
    check_eq("fd_period", 32'(bus.frame_done), 32'h1);

    // Load mid-frame at digit 1: current frame untouched, next frame shows 12AF
    step(7);
    check_eq("mid_d1_an", 32'(bus.an), 32'h4);
    load_val(16'h12AF, 4'b0000);
    check_eq("mid_pend", 32'(bus.pending), 32'h1);
    check_eq("mid_d1_seg", 32'(bus.seg), 32'(S0));
    step(5);
    check_eq("mid_d2_an", 32'(bus.an), 32'h2);
    check_eq("mid_d2_seg", 32'(bus.seg), 32'(S0));
    step(6);
    check_eq("mid_d3_an", 32'(bus.an), 32'h1);
    check_eq("mid_d3_seg", 32'(bus.seg), 32'(S0));
    step(4);
    check_eq("mid_pend_hold", 32'(bus.pending), 32'h1);
    step(1);
    check_eq("mid_fd", 32'(bus.frame_done), 32'h1);
    check_eq("mid_pend_clr", 32'(bus.pending), 32'h0);
    check_frame("v12af", S1, S2, SA, SF, 4'b1111);

    // Leading-zero suppression
    bus.lz_blank = 1'b1;
    load_val(16'h0005, 4'b0000);
    wait_fd("lz5");
    check_frame("lz5", OFF, OFF, OFF, S5, 4'b1111);
    load_val(16'h0000, 4'b0000);
    wait_fd("lz0");
    check_frame("lz0", OFF, OFF, OFF, S0, 4'b1111);
    bus.lz_blank = 1'b0;

    // Two loads within one frame: last one wins
    wait_fd("two_a");
    step(3);
    load_val(16'h1111, 4'b0000);
    step(5);
    load_val(16'h2222, 4'b0000);
    check_eq("two_pend", 32'(bus.pending), 32'h1);
    wait_fd("two_b");
    check_frame("last_wins", S2, S2, S2, S2, 4'b1111);

    // Load on the exact frame-end cycle
    load_val(16'h3333, 4'b0000);
    step(3);
    bus.din  = 16'h4444;
    bus.load = 1'b1;
    step(1);
    bus.load = 1'b0;
    check_eq("fe_fd", 32'(bus.frame_done), 32'h1);
    check_eq("fe_pend", 32'(bus.pending), 32'h1);
    check_frame("fe_old", S3, S3, S3, S3, 4'b1111);
    wait_fd("fe_next");
    check_eq("fe_pend_clr", 32'(bus.pending), 32'h0);
    check_frame("fe_new", S4, S4, S4, S4, 4'b1111);

    // Drop en mid-DRIVE, load while idle, then re-enable
    bus.en = 1'b0;
    step(1);
    check_eq("en_drop_an", 32'(bus.an), 32'h0);
    step(2);
    load_val(16'hBEEF, 4'b1010);
    bus.dp_in = 4'b0000;
    check_eq("idle_pend", 32'(bus.pending), 32'h0);
    check_eq("idle_an", 32'(bus.an), 32'h0);
    check_eq("idle_seg", 32'(bus.seg), 32'h7F);
    check_eq("idle_dp", 32'(bus.dp), 32'h1);
    step(3);
    check_eq("idle_dark", 32'(bus.an), 32'h0);
    bus.en = 1'b1;
    step(1);
    check_eq("beef_pre_an", 32'(bus.an), 32'h0);
    step(1);
    check_eq("beef_first_an", 32'(bus.an), 32'h8);
    check_eq("beef_first_seg", 32'(bus.seg), 32'(SB));
    check_eq("beef_first_dp", 32'(bus.dp), 32'h0);
    wait_fd("beef");
    check_frame("beef", SB, SE, SE, SF, 4'b0101);

    // Reset mid-BLANK with a pending value
    load_val(16'h7777, 4'b0000);
    check_eq("rst_pre_pend", 32'(bus.pending), 32'h1);
    step(2);
    check_eq("rst_pre_an", 32'(bus.an), 32'h1);
    rst = 1'b1;
    #1;
    check_eq("arst_an", 32'(bus.an), 32'h0);
    check_eq("arst_seg", 32'(bus.seg), 32'h7F);
    check_eq("arst_dp", 32'(bus.dp), 32'h1);
    check_eq("arst_pend", 32'(bus.pending), 32'h0);
    step(2);
    rst = 1'b0;
    step(2);
    check_eq("post_rst_an", 32'(bus.an), 32'h8);
    check_eq("post_rst_seg", 32'(bus.seg), 32'(S0));
    check_eq("post_rst_pend", 32'(bus.pending), 32'h0);
    wait_fd("post_rst");
    check_frame("post_rst", S0, S0, S0, S0, 4'b1111);
    check_eq("post_rst_pend2", 32'(bus.pending), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
